// File: rtl/atomic_region_monitor_pkg.sv
// atomic_region_monitor_pkg: state encoding, cause codes and sizing shared by the monitor files
package atomic_region_monitor_pkg;
  localparam int MAX_REGIONS = 8;
  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_ACTIVE = 2'd1,
    S_KILL   = 2'd2
  } state_t;
  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_ENTRY = 3'd1,
    C_EXIT  = 3'd2,
    C_IRQ   = 3'd3,
    C_DONE  = 3'd4
  } cause_t;
endpackage

// File: rtl/atomic_region_monitor_region_match.sv
// atomic_region_monitor_region_match: combinational pc decode for one protected region
module atomic_region_monitor_region_match #(
  parameter logic [15:0] BASE = 16'hA000,
  parameter logic [15:0] LAST = 16'hA0FE,
  parameter logic [15:0] EXIT = 16'hA0FE
) (
  input  logic [15:0] i_pc,
  output logic        o_in,
  output logic        o_base,
  output logic        o_exit
);
  assign o_in   = (i_pc >= BASE) && (i_pc <= LAST);
  assign o_base = i_pc == BASE;
  assign o_exit = i_pc == EXIT;
endmodule

// File: rtl/atomic_region_monitor.sv
// atomic_region_monitor: enforces atomic entry/exit of protected code regions and requests reset on violation
module atomic_region_monitor
  import atomic_region_monitor_pkg::*;
#(
  parameter int                    N_REGIONS     = 2,
  parameter logic [16*N_REGIONS-1:0] REGION_BASE = {16'hA100, 16'hA000},
  parameter logic [16*N_REGIONS-1:0] REGION_LAST = {16'hA1FE, 16'hA0FE},
  parameter logic [16*N_REGIONS-1:0] REGION_EXIT = {16'hA1FE, 16'hA0FE},
  parameter logic [N_REGIONS-1:0]  RESET_ON_DONE = 2'b01,
  parameter logic [15:0]           RESET_HANDLER = 16'hFFFE,
  parameter logic [7:0]            RESET_HOLD    = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        irq,
  output logic        res,
  output logic        violation,
  output logic [2:0]  cause,
  output logic [2:0]  region
);
  localparam logic [7:0] ROD = 8'(RESET_ON_DONE);
  logic [7:0] w_in, w_base, w_exit;
  logic [2:0] w_first;
  logic       w_any;
  state_t     r_state, w_nstate;
  cause_t     r_cause, w_ncause;
  logic [2:0] r_k, w_nk, r_region, w_nregion;
  logic       r_at_exit, r_viol, w_nviol;
  logic [7:0] r_hold;
  genvar g;
  generate
    for (g = 0; g < MAX_REGIONS; g++) begin : g_rm
      if (g < N_REGIONS) begin : g_on
        atomic_region_monitor_region_match #(
          .BASE(REGION_BASE[16*g +: 16]),
          .LAST(REGION_LAST[16*g +: 16]),
          .EXIT(REGION_EXIT[16*g +: 16])
        ) u_match (
          .i_pc  (pc),
          .o_in  (w_in[g]),
          .o_base(w_base[g]),
          .o_exit(w_exit[g])
        );
      end else begin : g_off
        assign w_in[g]   = 1'b0;
        assign w_base[g] = 1'b0;
        assign w_exit[g] = 1'b0;
      end
    end
  endgenerate
  // overlapping regions resolve to the lowest index
  always_comb begin
    w_first = 3'd0;
    for (int i = MAX_REGIONS - 1; i >= 0; i--) w_first = w_in[i] ? 3'(i) : w_first;
  end
  assign w_any = |w_in;
  always_comb begin
    w_nstate  = r_state;
    w_nk      = r_k;
    w_ncause  = r_cause;
    w_nregion = r_region;
    w_nviol   = 1'b0;
    case (r_state)
      S_RUN: if (w_any) begin
        w_nregion = w_first;
        if (w_base[w_first]) begin
          w_nstate = S_ACTIVE;
          w_nk     = w_first;
        end else begin
          w_nstate = S_KILL;
          w_ncause = C_ENTRY;
          w_nviol  = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (irq) begin
          w_nstate = S_KILL;
          w_ncause = C_IRQ;
          w_nviol  = 1'b1;
        end else if (w_exit[r_k] && ROD[r_k]) begin
          w_nstate = S_KILL;
          w_ncause = C_DONE;
        end else if (!w_in[r_k] && r_at_exit) begin
          w_nstate = S_RUN;
        end else if (!w_in[r_k] || w_first != r_k) begin
          w_nstate = S_KILL;
          w_ncause = C_EXIT;
          w_nviol  = 1'b1;
        end
      end
      S_KILL: if (r_hold >= RESET_HOLD - 8'd1 && pc == RESET_HANDLER) begin
        w_nstate = S_RUN;
        w_ncause = C_NONE;
      end
      default: w_nstate = S_KILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_KILL;
      r_k       <= 3'd0;
      r_at_exit <= 1'b0;
      r_hold    <= 8'd0;
      r_viol    <= 1'b0;
      r_cause   <= C_NONE;
      r_region  <= 3'd0;
    end else begin
      r_state   <= w_nstate;
      r_k       <= w_nk;
      r_viol    <= w_nviol;
      r_cause   <= w_ncause;
      r_region  <= w_nregion;
      r_at_exit <= (r_state == S_ACTIVE) && (w_nstate == S_ACTIVE) && w_exit[r_k];
      r_hold    <= (r_state != S_KILL || w_nstate != S_KILL) ? 8'd0 :
                   (r_hold >= RESET_HOLD) ? r_hold : r_hold + 8'd1;
    end
  end
  assign res       = r_state == S_KILL;
  assign violation = r_viol;
  assign cause     = r_cause;
  assign region    = r_region;
endmodule

// File: tb/tb_atomic_region_monitor.sv
// tb_atomic_region_monitor: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_atomic_region_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'hFFFE;
  logic        irq = 1'b0;
  logic        res, violation;
  logic [2:0]  cause, region;
  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  atomic_region_monitor dut (
    .clk(clk), .rst(rst), .pc(pc), .irq(irq),
    .res(res), .violation(violation), .cause(cause), .region(region)
  );
  always #5 clk = ~clk;
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {res, violation, cause, region};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got res=%b viol=%b cause=%0d region=%0d, want res=%b viol=%b cause=%0d region=%0d",
                   e.name, act[7], act[6], act[5:3], act[2:0], e.v[7], e.v[6], e.v[5:3], e.v[2:0]);
        end
      end
    end
  end
  task automatic step(input logic r, input logic [15:0] p, input logic i, input logic e_res,
                      input logic e_v, input logic [2:0] e_c, input logic [2:0] e_r, input string n);
    exp_t e;
    @(negedge clk);
    rst = r;
    pc = p;
    irq = i;
    e.name = n;
    e.v = {e_res, e_v, e_c, e_r};
    q.push_back(e);
    @(posedge clk);
  endtask
  task automatic release_seq(input logic [2:0] rg, input string n);
    for (int i = 0; i < 3; i++) step(0, 16'hFFFE, 0, 1, 0, 0, rg, n);
    step(0, 16'hFFFE, 0, 0, 0, 0, rg, n);
  endtask
  task automatic por_run();
    step(1, 16'hFFFE, 0, 1, 0, 0, 0, "rst");
    release_seq(0, "por_release");
  endtask
  initial begin
    // 1 legal call into region 0, DONE forces reset
    por_run();
    step(0, 16'hA000, 0, 0, 0, 0, 0, "t1_entry");
    for (int a = 'hA002; a <= 'hA0FC; a += 2) step(0, 16'(a), 0, 0, 0, 0, 0, "t1_body");
    step(0, 16'hA0FE, 0, 1, 0, 4, 0, "t1_done");
    step(0, 16'h0000, 0, 1, 0, 4, 0, "t1_done_hold");
    // 2 legal region 1 pass-through
    por_run();
    for (int a = 'hA100; a <= 'hA1FE; a += 2) step(0, 16'(a), 0, 0, 0, 0, 1, "t2_body");
    step(0, 16'h4400, 0, 0, 0, 0, 1, "t2_exit");
    step(0, 16'h4402, 0, 0, 0, 0, 1, "t2_run");
    // 3 mid-region entry
    por_run();
    step(0, 16'h4400, 0, 0, 0, 0, 0, "t3_run");
    step(0, 16'hA104, 0, 1, 1, 1, 1, "t3_entry_viol");
    step(0, 16'h0000, 0, 1, 0, 1, 1, "t3_pulse_end");
    // 4 early exit from region 1
    por_run();
    step(0, 16'hA100, 0, 0, 0, 0, 1, "t4_entry");
    step(0, 16'hA120, 0, 0, 0, 0, 1, "t4_inside");
    step(0, 16'h4400, 0, 1, 1, 2, 1, "t4_early_exit");
    step(0, 16'h4400, 0, 1, 0, 2, 1, "t4_pulse_end");
    // 5 irq inside region 0, then hold-off of the release
    por_run();
    step(0, 16'hA000, 0, 0, 0, 0, 0, "t5_entry");
    step(0, 16'hA010, 1, 1, 1, 3, 0, "t5_irq");
    step(0, 16'hFFFE, 0, 1, 0, 3, 0, "t5_kill1");
    step(0, 16'hFFFE, 0, 1, 0, 3, 0, "t5_kill2");
    step(0, 16'hFFFE, 0, 1, 0, 3, 0, "t5_kill3");
    step(0, 16'hFFFE, 0, 0, 0, 0, 0, "t5_release");
    // 6 rst while active is not a violation, re-entry legal afterwards
    por_run();
    step(0, 16'hA100, 0, 0, 0, 0, 1, "t6_entry");
    step(0, 16'hA102, 0, 0, 0, 0, 1, "t6_inside");
    step(1, 16'hA104, 0, 1, 0, 0, 0, "t6_rst");
    release_seq(0, "t6_release");
    step(0, 16'hA100, 0, 0, 0, 0, 1, "t6_reentry");
    step(0, 16'hA102, 0, 0, 0, 0, 1, "t6_inside2");
    // boundaries: just past LAST, entry at LAST, saturated hold releases at once
    por_run();
    step(0, 16'hA0FF, 0, 0, 0, 0, 0, "b_past_last0");
    step(0, 16'hA1FF, 0, 0, 0, 0, 0, "b_past_last1");
    step(0, 16'hA0FE, 0, 1, 1, 1, 0, "b_entry_at_last");
    for (int i = 0; i < 5; i++) step(0, 16'h0000, 0, 1, 0, 1, 0, "b_kill_wait");
    step(0, 16'hFFFE, 0, 0, 0, 0, 0, "b_sat_release");
    // cross-region jump from region 0 into region 1
    step(0, 16'hA000, 0, 0, 0, 0, 0, "x_entry");
    step(0, 16'hA100, 0, 1, 1, 2, 0, "x_jump");
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
